// File: rtl/program_loader.sv
// Boot-stage loader: receives a framed, XOR-checksummed byte image and writes it into
// instruction memory from PC 0, holding the core in reset until the image verifies.
module program_loader #(
    parameter int PC_WIDTH   = 10,
    parameter int IMEM_DEPTH = 1024,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [BYTE_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [PC_WIDTH-1:0]   imem_addr,
    output logic [BYTE_WIDTH-1:0] imem_wdata,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(IMEM_DEPTH);

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [BYTE_WIDTH-1:0] xor_q, xor_d;
    logic [PC_WIDTH:0]     addr_q, addr_d;
    logic                  we_d;
    logic [PC_WIDTH-1:0]   waddr_d;
    logic [BYTE_WIDTH-1:0] wdata_d;
    logic                  ready_d;
    logic                  accept;
    logic [15:0]           len_full;
    logic [15:0]           addr_inc;

    assign accept   = in_valid & in_ready;
    assign len_full = {in_data[7:0], len_q[7:0]};
    assign addr_inc = 16'(addr_q) + 16'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        xor_d   = xor_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        waddr_d = imem_addr;
        wdata_d = imem_wdata;

        // A start pulse overrides any byte accepted in the same cycle.
        if (start) begin
            state_d = S_LEN_LO;
            len_d   = '0;
            xor_d   = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                S_LEN_LO: begin
                    if (accept) begin
                        len_d[7:0] = in_data[7:0];
                        state_d    = S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_d  = len_full;
                        addr_d = '0;
                        xor_d  = '0;
                        if (len_full == 16'd0)
                            state_d = S_CSUM;
                        else if (len_full > MAX_LEN)
                            state_d = S_ERROR;
                        else
                            state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q[PC_WIDTH-1:0];
                        wdata_d = in_data;
                        xor_d   = xor_q ^ in_data;
                        addr_d  = addr_q + 1'b1;
                        if (addr_inc == len_q)
                            state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (accept)
                        state_d = (in_data == xor_q) ? S_RUN : S_ERROR;
                end
                default: ;
            endcase
        end

        ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                  (state_d == S_DATA)   || (state_d == S_CSUM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            xor_q      <= '0;
            addr_q     <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            xor_q      <= xor_d;
            addr_q     <= addr_d;
            in_ready   <= ready_d;
            imem_we    <= we_d;
            imem_addr  <= waddr_d;
            imem_wdata <= wdata_d;
            core_reset <= (state_d != S_RUN);
            load_done  <= (state_d == S_RUN);
            load_error <= (state_d == S_ERROR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected imem writes are queued by the stimulus
// and popped by an independent write monitor; status outputs are checked inline.
module tb_program_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       imem_we;
    logic [9:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       core_reset;
    logic       load_done;
    logic       load_error;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t         sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [9:0]  last_addr = '0;

    program_loader #(
        .PC_WIDTH(10),
        .IMEM_DEPTH(1024),
        .BYTE_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .load_done(load_done),
        .load_error(load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Write monitor: every imem_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h required no write",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("imem_write", 32'({imem_addr, imem_wdata}), 32'({e.addr, e.data}));
                last_addr = imem_addr;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned gap_pct);
        int unsigned n;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got %b required 1", in_ready);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b, input logic [9:0] a, input int unsigned gap_pct);
        sb.push_back('{addr: a, data: b});
        send_byte(b, gap_pct);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] d;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_imem_we",    32'(imem_we),    32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_load_done",  32'(load_done),  32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // 1: N=3 good image
        pulse_start();
        chk("t1_ready_after_start", 32'(in_ready), 32'd1);
        send_byte(8'h03, 0); send_byte(8'h00, 0);
        send_data(8'h2B, 10'd0, 0);
        send_data(8'h2B, 10'd1, 0);
        send_data(8'h3E, 10'd2, 0);
        chk("t1_core_reset_pre", 32'(core_reset), 32'd1);
        send_byte(8'h3E, 0);
        chk("t1_load_done",  32'(load_done),  32'd1);
        chk("t1_core_reset", 32'(core_reset), 32'd0);
        chk("t1_in_ready",   32'(in_ready),   32'd0);
        chk("t1_load_error", 32'(load_error), 32'd0);

        // 2: bad checksum (start while RUN re-asserts core reset)
        pulse_start();
        chk("t2_core_reset_on_start", 32'(core_reset), 32'd1);
        chk("t2_done_cleared",        32'(load_done),  32'd0);
        send_byte(8'h03, 0); send_byte(8'h00, 0);
        send_data(8'h2B, 10'd0, 0);
        send_data(8'h2B, 10'd1, 0);
        send_data(8'h3E, 10'd2, 0);
        send_byte(8'h00, 0);
        chk("t2_load_error", 32'(load_error), 32'd1);
        chk("t2_core_reset", 32'(core_reset), 32'd1);
        chk("t2_load_done",  32'(load_done),  32'd0);

        // 3: empty image, then oversize length 1025
        pulse_start();
        chk("t3_error_cleared", 32'(load_error), 32'd0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("t3_empty_done", 32'(load_done), 32'd1);
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h04, 0);
        chk("t3_oversize_error", 32'(load_error), 32'd1);
        chk("t3_oversize_ready", 32'(in_ready),   32'd0);

        // 4: full 1024-byte image with ~30% idle gaps
        pulse_start();
        send_byte(8'h00, 30); send_byte(8'h04, 30);
        x = '0;
        for (int i = 0; i < 1024; i++) begin
            d = 8'(i * 37 + 5);
            x = x ^ d;
            send_data(d, 10'(i), 30);
        end
        send_byte(x, 30);
        chk("t4_load_done", 32'(load_done), 32'd1);
        chk("t4_last_addr", 32'(last_addr), 32'd1023);

        // 5: restart mid-DATA, with start colliding with an accept
        pulse_start();
        send_byte(8'h08, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 5; i++) send_data(8'(8'hC0 + i), 10'(i), 0);
        in_valid = 1'b1; in_data = 8'h77; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        chk("t5_restart_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_data(8'hAA, 10'd0, 0);
        send_data(8'h55, 10'd1, 0);
        send_byte(8'hFF, 0);
        chk("t5_load_done", 32'(load_done), 32'd1);
        pulse_start();
        chk("t5_core_reset_run_start", 32'(core_reset), 32'd1);

        // 6: async reset mid-DATA
        send_byte(8'h05, 0); send_byte(8'h00, 0);
        send_data(8'h11, 10'd0, 0);
        send_data(8'h22, 10'd1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_in_ready",   32'(in_ready),   32'd0);
        chk("t6_imem_we",    32'(imem_we),    32'd0);
        chk("t6_imem_addr",  32'(imem_addr),  32'd0);
        chk("t6_imem_wdata", 32'(imem_wdata), 32'd0);
        chk("t6_core_reset", 32'(core_reset), 32'd1);
        chk("t6_load_done",  32'(load_done),  32'd0);
        chk("t6_load_error", 32'(load_error), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_ready",      32'(in_ready),   32'd0);
        chk("t6_idle_core_reset", 32'(core_reset), 32'd1);
        pulse_start();
        chk("t6_start_ready", 32'(in_ready), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
